gpr_wb_sched: RTL and testbench

//  Write-port scheduler and scoreboard for the GPR file (single write port, two read ports).
//  - Arbitrates two writeback sources onto the one GPR write port:
//    - wb0: in-order pipeline ALU.
//    - wb1: long-latency unit, e.g. LSU/divider.
//  - Tracks registers with pending long-latency results and stalls issue on RAW/WAW hazards.
//  - Sits between decode/issue, the execution units and gpr; drives gpr addr_w/data_w directly.

---
 rtl/gpr_wb_sched_pkg.sv | 14 +
 rtl/gpr_scoreboard.sv | 46 ++++
 rtl/gpr_wb_sched.sv | 98 +++++++++
 tb/tb_gpr_wb_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_sched_pkg.sv
// Shared GPR file constants for the writeback scheduler and its scoreboard.
package gpr_wb_sched_pkg;

  localparam int GPR_WIDTH  = 32;
  localparam int GPR_NUM    = 32;
  localparam int REG_X0     = 0;
  localparam int STARVE_DEF = 4;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit scoreboard: one bit per GPR, set on long issue, cleared on long
// writeback, with a three-index hazard lookup. Register x0 is never busy.
module gpr_scoreboard
  import gpr_wb_sched_pkg::*;
#(
  parameter int NUM = GPR_NUM,
  parameter int AW  = $clog2(NUM)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           set_en,
  input  logic [AW-1:0]  set_idx,
  input  logic           clr_en,
  input  logic [AW-1:0]  clr_idx,
  input  logic [AW-1:0]  rs1,
  input  logic [AW-1:0]  rs2,
  input  logic [AW-1:0]  rd,
  output logic           hazard,
  output logic [NUM-1:0] busy
);

  logic [NUM-1:0] busy_reg;
  logic [NUM-1:0] busy_next;

  assign busy_next[REG_X0] = 1'b0;

  // Set takes precedence only in theory; issue stalls on a busy rd, so a set
  // and a clear of the same register never coincide.
  genvar gi;
  generate
    for (gi = 1; gi < NUM; gi++) begin : g_busy
      assign busy_next[gi] = (set_en && set_idx == AW'(gi)) ? 1'b1 :
                             (clr_en && clr_idx == AW'(gi)) ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign hazard = busy_reg[rs1] | busy_reg[rs2] | busy_reg[rd];
  assign busy   = busy_reg;

endmodule

// File: rtl/gpr_wb_sched.sv
// GPR write-port scheduler: arbitrates ALU (wb0) and long-latency (wb1)
// writebacks with starvation protection, and stalls issue on RAW/WAW hazards.
module gpr_wb_sched
  import gpr_wb_sched_pkg::*;
#(
  parameter int WIDTH      = GPR_WIDTH,
  parameter int NUM        = GPR_NUM,
  parameter int STARVE_MAX = STARVE_DEF,
  parameter int AW         = $clog2(NUM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs1,
  input  logic [AW-1:0]    issue_rs2,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_long,
  output logic             issue_stall,
  input  logic             wb0_valid,
  input  logic [AW-1:0]    wb0_rd,
  input  logic [WIDTH-1:0] wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [AW-1:0]    wb1_rd,
  input  logic [WIDTH-1:0] wb1_data,
  output logic             wb1_ready,
  output logic [AW-1:0]    gpr_addr_w,
  output logic [WIDTH-1:0] gpr_data_w,
  output logic [NUM-1:0]   sb_busy
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] wait_cnt_reg;
  logic [CW-1:0] wait_cnt_next;
  logic          starved;
  logic          grant0;
  logic          grant1;
  logic          hazard;
  logic          set_en;

  assign starved = (wait_cnt_reg == STARVE_LIM);

  // Outputs are forced idle while reset is held, independent of the inputs.
  always_comb begin
    grant1     = 1'b0;
    grant0     = 1'b0;
    gpr_addr_w = '0;
    gpr_data_w = '0;
    if (!reset) begin
      grant1 = wb1_valid & (!wb0_valid | starved);
      grant0 = wb0_valid & !grant1;
      if (grant1) begin
        gpr_addr_w = wb1_rd;
        gpr_data_w = wb1_data;
      end else if (grant0) begin
        gpr_addr_w = wb0_rd;
        gpr_data_w = wb0_data;
      end
    end
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!wb1_valid || grant1)  wait_cnt_next = '0;
    else if (!starved)         wait_cnt_next = wait_cnt_reg + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_cnt_reg <= '0;
    else       wait_cnt_reg <= wait_cnt_next;
  end

  assign issue_stall = !reset & issue_valid & hazard;
  assign set_en      = issue_valid & !hazard & issue_long & (issue_rd != AW'(REG_X0));

  gpr_scoreboard #(
    .NUM (NUM),
    .AW  (AW)
  ) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .set_en  (set_en),
    .set_idx (issue_rd),
    .clr_en  (grant1),
    .clr_idx (wb1_rd),
    .rs1     (issue_rs1),
    .rs2     (issue_rs2),
    .rd      (issue_rd),
    .hazard  (hazard),
    .busy    (sb_busy)
  );

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed testbench for gpr_wb_sched with hand-computed expectations.
module tb_gpr_wb_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0;
  logic [4:0]  issue_rs2 = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_long = 1'b0;
  logic        issue_stall;
  logic        wb0_valid = 1'b0;
  logic [4:0]  wb0_rd = '0;
  logic [31:0] wb0_data = '0;
  logic        wb0_ready;
  logic        wb1_valid = 1'b0;
  logic [4:0]  wb1_rd = '0;
  logic [31:0] wb1_data = '0;
  logic        wb1_ready;
  logic [4:0]  gpr_addr_w;
  logic [31:0] gpr_data_w;
  logic [31:0] sb_busy;

  int tests_run = 0;
  int tests_failed = 0;

  gpr_wb_sched dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_long  (issue_long),
    .issue_stall (issue_stall),
    .wb0_valid   (wb0_valid),
    .wb0_rd      (wb0_rd),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_rd      (wb1_rd),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .gpr_addr_w  (gpr_addr_w),
    .gpr_data_w  (gpr_data_w),
    .sb_busy     (sb_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic lng);
    issue_valid = v;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
    issue_long  = lng;
  endtask

  initial begin
    // Outputs idle while reset is held, even with requests present
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h11;
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
    #2;
    check("rst_wb0_ready", 64'(wb0_ready), 64'd0);
    check("rst_addr", 64'(gpr_addr_w), 64'd0);
    check("rst_data", 64'(gpr_data_w), 64'd0);
    check("rst_stall", 64'(issue_stall), 64'd0);
    check("rst_busy", 64'(sb_busy), 64'd0);
    wb0_valid = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // 1. Reset mid-operation
    issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    #1 check("t1_issue_stall", 64'(issue_stall), 64'd0);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb0_valid = 1'b1; wb0_rd = 5'd6; wb0_data = 32'h66;
    #1 check("t1_busy5", 64'(sb_busy), 64'h20);
    #2 reset = 1'b1;
    #1;
    check("t1_async_busy", 64'(sb_busy), 64'd0);
    check("t1_async_addr", 64'(gpr_addr_w), 64'd0);
    #1 reset = 1'b0;
    wb0_valid = 1'b0;
    tick();
    issue(1'b1, 5'd5, 5'd0, 5'd11, 1'b0);
    #1 check("t1_x5_nostall", 64'(issue_stall), 64'd0);
    tick();

    // 2. Long RAW
    issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    #1 check("t2_long_issue", 64'(issue_stall), 64'd0);
    tick();
    issue(1'b1, 5'd7, 5'd2, 5'd8, 1'b0);
    #1;
    check("t2_busy7", 64'(sb_busy), 64'h80);
    check("t2_raw_stall", 64'(issue_stall), 64'd1);
    tick();
    wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'hDEADBEEF;
    #1;
    check("t2_wb1_ready", 64'(wb1_ready), 64'd1);
    check("t2_addr", 64'(gpr_addr_w), 64'd7);
    check("t2_data", 64'(gpr_data_w), 64'hDEADBEEF);
    check("t2_stall_same", 64'(issue_stall), 64'd1);
    tick();
    wb1_valid = 1'b0;
    #1;
    check("t2_busy_clr", 64'(sb_busy), 64'd0);
    check("t2_issue_go", 64'(issue_stall), 64'd0);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // 3. Conflict
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h22;
    #1;
    check("t3_wb0_ready", 64'(wb0_ready), 64'd1);
    check("t3_wb1_wait", 64'(wb1_ready), 64'd0);
    check("t3_addr3", 64'(gpr_addr_w), 64'd3);
    check("t3_data11", 64'(gpr_data_w), 64'h11);
    tick();
    wb0_valid = 1'b0;
    #1;
    check("t3_wb1_ready", 64'(wb1_ready), 64'd1);
    check("t3_addr4", 64'(gpr_addr_w), 64'd4);
    check("t3_data22", 64'(gpr_data_w), 64'h22);
    tick();
    wb1_valid = 1'b0;
    tick();

    // 4. Starvation: four losses, win on the fifth
    wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_lose%0d", i), 64'(wb1_ready), 64'd0);
      tick();
    end
    #1;
    check("t4_wb1_win", 64'(wb1_ready), 64'd1);
    check("t4_wb0_held", 64'(wb0_ready), 64'd0);
    check("t4_addr2", 64'(gpr_addr_w), 64'd2);
    tick();
    wb1_valid = 1'b0;
    #1 check("t4_wb0_after", 64'(wb0_ready), 64'd1);
    tick();
    wb0_valid = 1'b0;

    // 5. x0
    issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 32'hFFFF;
    #1;
    check("t5_busy", 64'(sb_busy), 64'd0);
    check("t5_wb0_ready", 64'(wb0_ready), 64'd1);
    check("t5_addr0", 64'(gpr_addr_w), 64'd0);
    tick();
    wb0_valid = 1'b0;

    // 6. WAW and simultaneous set/clear
    issue(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
    tick();
    issue(1'b1, 5'd1, 5'd2, 5'd9, 1'b0);
    #1;
    check("t6_busy9", 64'(sb_busy), 64'h200);
    check("t6_waw_stall", 64'(issue_stall), 64'd1);
    tick();
    issue(1'b1, 5'd1, 5'd2, 5'd10, 1'b1);
    wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h99;
    #1;
    check("t6_set_go", 64'(issue_stall), 64'd0);
    check("t6_clr_ready", 64'(wb1_ready), 64'd1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb1_valid = 1'b0;
    #1 check("t6_busy10", 64'(sb_busy), 64'h400);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
